// File: rtl/gym_pkg.sv
// Shared types and constants for the gym map movement logic.
//   dir_t          : facing/walk direction encoding shared with the renderer and bounds checker
//   KEY_*          : keycodes that request a walk
//   SCREEN_W/H     : visible area in pixels
//   mover_state_t  : movement controller states
//   decode_key()   : keycode to {valid, direction}
package gym_pkg;

  typedef enum logic [1:0] {
    DOWN  = 2'd0,
    UP    = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  typedef enum logic [1:0] {
    StIdle,
    StTurn,
    StWalk
  } mover_state_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } key_dec_t;

  function automatic key_dec_t decode_key(input logic [7:0] key);
    key_dec_t dec;
    dec.valid = 1'b1;
    dec.dir   = UP;
    case (key)
      KEY_W:   dec.dir = UP;
      KEY_S:   dec.dir = DOWN;
      KEY_A:   dec.dir = LEFT;
      KEY_D:   dec.dir = RIGHT;
      default: dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/gym_char_mover_if.sv
// Player movement bus between the keyboard/bounds-checker side and the mover.
//   keycode, move_en, atBounds           : towards the mover
//   direction, charxcurrpos, charycurrpos,
//   moving, walk_frame                   : from the mover to the bounds checker / sprite renderer
// modport slave is the mover; modport master is the surrounding gym logic.
interface gym_char_mover_if;

  logic [7:0] keycode;
  logic       move_en;
  logic       atBounds;
  logic [1:0] direction;
  logic [9:0] charxcurrpos;
  logic [9:0] charycurrpos;
  logic       moving;
  logic [1:0] walk_frame;

  modport master (
    output keycode,
    output move_en,
    output atBounds,
    input  direction,
    input  charxcurrpos,
    input  charycurrpos,
    input  moving,
    input  walk_frame
  );

  modport slave (
    input  keycode,
    input  move_en,
    input  atBounds,
    output direction,
    output charxcurrpos,
    output charycurrpos,
    output moving,
    output walk_frame
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector for the vsync-rate frame level.
//   i_clk        : system clock
//   i_reset      : synchronous active-high reset
//   i_frame_clk  : frame level, already synchronous to i_clk
//   o_frame_tick : one-cycle pulse on each rising edge of i_frame_clk
module frame_tick_gen (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_frame_clk,
  output logic o_frame_tick
);

  logic r_frame_clk_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_clk_q <= 1'b0;
    end else begin
      r_frame_clk_q <= i_frame_clk;
    end
  end

  assign o_frame_tick = i_frame_clk & ~r_frame_clk_q;

endmodule

// File: rtl/gym_char_mover.sv
// Player movement controller: turns a held key into a TILE_PX-pixel walk, one pixel per frame.
//   Clk       : system clock
//   Reset     : synchronous active-high reset
//   frame_clk : vsync-rate level; only its rising edge is used
//   bus       : slave side of gym_char_mover_if (key/enable/bounds in, position/facing/anim out)
module gym_char_mover
  import gym_pkg::*;
#(
  parameter int unsigned TILE_PX  = 16,
  parameter int unsigned ANIM_DIV = 4,
  parameter int unsigned START_X  = 224,
  parameter int unsigned START_Y  = 340
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  gym_char_mover_if.slave   bus
);

  localparam int unsigned CntW = $clog2(TILE_PX) + 1;
  localparam int unsigned DivW = $clog2(ANIM_DIV) + 1;

  logic            w_frame_tick;
  key_dec_t        w_key;
  logic            w_at_edge;
  logic [9:0]      w_next_x;
  logic [9:0]      w_next_y;
  logic [CntW-1:0] w_cnt_inc;
  logic [DivW-1:0] w_div_inc;

  mover_state_t    r_state;
  dir_t            r_dir;
  logic [9:0]      r_x;
  logic [9:0]      r_y;
  logic            r_moving;
  logic [1:0]      r_walk_frame;
  logic [CntW-1:0] r_step_cnt;
  logic [DivW-1:0] r_anim_div;

  frame_tick_gen u_frame_tick_gen (
    .i_clk        (Clk),
    .i_reset      (Reset),
    .i_frame_clk  (frame_clk),
    .o_frame_tick (w_frame_tick)
  );

  assign w_key     = decode_key(bus.keycode);
  assign w_cnt_inc = r_step_cnt + 1'b1;
  assign w_div_inc = r_anim_div + 1'b1;

  // Candidate one-pixel step; w_at_edge blocks it so the 10-bit position never wraps.
  always_comb begin
    w_at_edge = 1'b0;
    w_next_x  = r_x;
    w_next_y  = r_y;
    case (r_dir)
      DOWN: begin
        w_at_edge = (r_y == 10'(SCREEN_H - 1));
        w_next_y  = r_y + 10'd1;
      end
      UP: begin
        w_at_edge = (r_y == 10'd0);
        w_next_y  = r_y - 10'd1;
      end
      LEFT: begin
        w_at_edge = (r_x == 10'd0);
        w_next_x  = r_x - 10'd1;
      end
      RIGHT: begin
        w_at_edge = (r_x == 10'(SCREEN_W - 1));
        w_next_x  = r_x + 10'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state      <= StIdle;
      r_dir        <= UP;
      r_x          <= 10'(START_X);
      r_y          <= 10'(START_Y);
      r_moving     <= 1'b0;
      r_walk_frame <= 2'd0;
      r_step_cnt   <= '0;
      r_anim_div   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_frame_tick && bus.move_en && w_key.valid) begin
            r_dir      <= w_key.dir;
            r_step_cnt <= '0;
            r_state    <= StTurn;
          end
        end
        // One settle cycle so atBounds reflects the newly latched direction.
        StTurn: begin
          r_state  <= StWalk;
          r_moving <= 1'b1;
        end
        StWalk: begin
          if (w_frame_tick && bus.move_en) begin
            if (bus.atBounds || w_at_edge) begin
              r_state      <= StIdle;
              r_moving     <= 1'b0;
              r_step_cnt   <= '0;
              r_walk_frame <= 2'd0;
              r_anim_div   <= '0;
            end else begin
              r_x        <= w_next_x;
              r_y        <= w_next_y;
              r_step_cnt <= w_cnt_inc;
              if (w_cnt_inc == CntW'(TILE_PX)) begin
                r_state      <= StIdle;
                r_moving     <= 1'b0;
                r_step_cnt   <= '0;
                r_walk_frame <= 2'd0;
                r_anim_div   <= '0;
              end else if (w_div_inc == DivW'(ANIM_DIV)) begin
                r_anim_div   <= '0;
                r_walk_frame <= r_walk_frame + 2'd1;
              end else begin
                r_anim_div <= w_div_inc;
              end
            end
          end
        end
        default: begin
          r_state  <= StIdle;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign bus.direction    = r_dir;
  assign bus.charxcurrpos = r_x;
  assign bus.charycurrpos = r_y;
  assign bus.moving       = r_moving;
  assign bus.walk_frame   = r_walk_frame;

endmodule

// File: tb/tb_gym_char_mover.sv
// Directed bench for gym_char_mover: default instance plus an instance starting at x=0.
module tb_gym_char_mover;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frame_clk = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  gym_char_mover_if bus ();
  gym_char_mover_if bus_edge ();

  gym_char_mover dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus.slave)
  );

  gym_char_mover #(
    .START_X (0),
    .START_Y (340)
  ) dut_edge (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .bus       (bus_edge.slave)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_clk pulse; returns on a falling Clk edge after the tick has been acted on.
  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.keycode = 8'h00;  bus.move_en = 1'b1;  bus.atBounds = 1'b0;
    bus_edge.keycode = 8'h00;  bus_edge.move_en = 1'b1;  bus_edge.atBounds = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;

    // 1. Reset and idle ticks with no key.
    do_ticks(2);
    check_eq("rst_x", bus.charxcurrpos, 224);
    check_eq("rst_y", bus.charycurrpos, 340);
    check_eq("rst_dir", bus.direction, 1);
    check_eq("rst_moving", bus.moving, 0);
    check_eq("rst_wf", bus.walk_frame, 0);

    // 2. One tile right with exact start latency.
    bus.keycode = 8'h07;
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    check_eq("d_dir_next", bus.direction, 3);
    check_eq("d_turn_moving", bus.moving, 0);
    @(negedge Clk);
    check_eq("d_walk_moving", bus.moving, 1);
    check_eq("d_x_nostep", bus.charxcurrpos, 224);
    bus.keycode = 8'h00;
    @(negedge Clk);
    do_tick();
    check_eq("d_x1", bus.charxcurrpos, 225);
    check_eq("d_wf1", bus.walk_frame, 0);
    do_ticks(3);
    check_eq("d_wf4", bus.walk_frame, 1);
    do_ticks(4);
    check_eq("d_wf8", bus.walk_frame, 2);
    do_ticks(4);
    check_eq("d_wf12", bus.walk_frame, 3);
    check_eq("d_x12", bus.charxcurrpos, 236);
    do_ticks(3);
    check_eq("d_moving15", bus.moving, 1);
    do_tick();
    check_eq("d_x16", bus.charxcurrpos, 240);
    check_eq("d_y16", bus.charycurrpos, 340);
    check_eq("d_idle", bus.moving, 0);
    check_eq("d_wf_clr", bus.walk_frame, 0);

    // 3. Blocked step downward.
    bus.keycode = 8'h16;
    do_tick();
    check_eq("s_dir", bus.direction, 0);
    bus.keycode = 8'h00;
    bus.atBounds = 1'b1;
    do_tick();
    check_eq("s_y", bus.charycurrpos, 340);
    check_eq("s_moving", bus.moving, 0);
    bus.atBounds = 1'b0;

    // 4. Mid-walk abort going up; key stays held through the walk.
    bus.keycode = 8'h1A;
    do_tick();
    check_eq("w_dir", bus.direction, 1);
    do_ticks(5);
    check_eq("w_y5", bus.charycurrpos, 335);
    check_eq("w_wf5", bus.walk_frame, 1);
    bus.atBounds = 1'b1;
    do_tick();
    bus.keycode = 8'h00;
    check_eq("w_y_abort", bus.charycurrpos, 335);
    check_eq("w_moving", bus.moving, 0);
    check_eq("w_wf_clr", bus.walk_frame, 0);
    bus.atBounds = 1'b0;

    // 5. Freeze mid-walk, then finish the tile (also proves the step counter restarted).
    bus.keycode = 8'h07;
    do_tick();
    bus.keycode = 8'h00;
    do_ticks(6);
    check_eq("f_x6", bus.charxcurrpos, 246);
    bus.move_en = 1'b0;
    do_ticks(10);
    check_eq("f_x_frozen", bus.charxcurrpos, 246);
    check_eq("f_moving_frozen", bus.moving, 1);
    check_eq("f_wf_frozen", bus.walk_frame, 1);
    bus.move_en = 1'b1;
    do_ticks(9);
    check_eq("f_x15", bus.charxcurrpos, 255);
    check_eq("f_moving15", bus.moving, 1);
    do_tick();
    check_eq("f_x16", bus.charxcurrpos, 256);
    check_eq("f_y16", bus.charycurrpos, 335);
    check_eq("f_idle", bus.moving, 0);

    // 6. Left edge on the x=0 instance, then reset mid-walk.
    check_eq("e_x0", bus_edge.charxcurrpos, 0);
    bus_edge.keycode = 8'h04;
    do_tick();
    check_eq("e_dir", bus_edge.direction, 2);
    do_tick();
    bus_edge.keycode = 8'h00;
    check_eq("e_x_stuck", bus_edge.charxcurrpos, 0);
    check_eq("e_moving", bus_edge.moving, 0);
    bus_edge.keycode = 8'h07;
    do_tick();
    bus_edge.keycode = 8'h00;
    do_ticks(3);
    check_eq("e_x3", bus_edge.charxcurrpos, 3);
    check_eq("e_walking", bus_edge.moving, 1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check_eq("r_edge_x", bus_edge.charxcurrpos, 0);
    check_eq("r_edge_moving", bus_edge.moving, 0);
    check_eq("r_edge_dir", bus_edge.direction, 1);
    check_eq("r_x", bus.charxcurrpos, 224);
    check_eq("r_y", bus.charycurrpos, 340);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gym_char_mover.md
# gym_char_mover

Player-movement controller for the gym map. Converts the held keycode into tile-sized walks, one pixel per video frame, and drives the registered character position and facing direction. Sits directly upstream of the gym bounds checker: it feeds that checker the direction and current position, and consumes its `atBounds` result before every pixel step. Outputs also go to the character sprite renderer.

## Interface
- `TILE_PX`, default 16: pixels per committed walk.
- `ANIM_DIV`, default 4: frame ticks per walk-animation frame.
- `START_X`, default 224: reset x position.
- `START_Y`, default 340: reset y position.

- `Clk`, input, 1: system clock; the only clock.
- `Reset`, input, 1: synchronous, active-high.
- `frame_clk`, input, 1: vsync-rate level, synchronous to `Clk`; the block uses only its rising edge.
- `keycode`, input, 8: current key. W=0x1A up, S=0x16 down, A=0x04 left, D=0x07 right; any other value means no key.
- `move_en`, input, 1: low freezes all movement (dialog or battle).
- `atBounds`, input, 1: combinational result of the bounds checker for the current `direction`/position.
- `direction`, output, 2: 0 down, 1 up, 2 left, 3 right.
- `charxcurrpos`, output, 10: registered character x.
- `charycurrpos`, output, 10: registered character y.
- `moving`, output, 1: high in WALK.
- `walk_frame`, output, 2: sprite animation frame.

## Operation
**Frame tick**
- `frame_tick = frame_clk & ~frame_clk_q`, where `frame_clk_q` is `frame_clk` registered.
- `frame_tick` lasts one `Clk` per rising edge.

**State machine: IDLE, TURN, WALK**
- IDLE:
  - Condition: `frame_tick && move_en && key valid`.
  - Action: load `direction` from the key, clear the step counter.
  - Next state: TURN.
- TURN:
  - Lasts exactly one cycle, so `atBounds` can settle on the new direction.
  - Next state: WALK unconditionally.
- WALK, on `frame_tick && move_en`:
  - If `atBounds` is high, or the step would leave 0..639 (x) / 0..479 (y): no move, go to IDLE.
  - Otherwise, step 1 pixel:
    - down: y+1
    - up: y−1
    - left: x−1
    - right: x+1
  - After the step, increment the counter.
  - When the counter reaches `TILE_PX`, go to IDLE.
- Keycode changes during TURN or WALK are ignored. The walk direction is latched.
- Held key: IDLE re-arms on the next frame tick, giving continuous walking with one idle frame between tiles.
- `move_en` low:
  - Ticks are ignored in every state.
  - State, position and counter hold.
  - Motion resumes on the first tick after `move_en` returns high.

**Animation**
- In WALK, a divider counts ticks. Every `ANIM_DIV` ticks, `walk_frame` increments, wrapping 3→0.
- Entering IDLE clears `walk_frame` and the divider.

**Widths**
- Position arithmetic is 10-bit unsigned.
- The edge guards make wrap-around impossible: x=0 never goes left, x=639 never goes right, and the same applies to y at 0/479.
- The step counter is `$clog2(TILE_PX)+1` bits.

## Timing
Reset values (synchronous, win over all other inputs):
- state = IDLE
- `charxcurrpos` = `START_X`, `charycurrpos` = `START_Y`
- `direction` = 1 (up)
- `moving` = 0, `walk_frame` = 0
- counters = 0, `frame_clk_q` = 0

Latencies:
- Key to direction: `direction` updates the cycle after the qualifying tick.
- Walk start: WALK is entered two cycles after the tick. The first pixel moves on the following frame tick, not the same one.
- Position: updates one cycle after the WALK tick. `atBounds` is sampled in the same cycle as the tick, using pre-step values.
- A tick landing in TURN or on a state-transition cycle is dropped; it is not queued.

Mid-walk cases:
- Reset mid-walk: position returns to start, no partial step is retained.
- `atBounds` rising mid-walk: the walk aborts at the current pixel. Counter and `walk_frame` clear.

## Structure
- Shared package `gym_pkg` holds:
  - `dir_t` enum (DOWN=0, UP=1, LEFT=2, RIGHT=3)
  - keycode constants
  - `SCREEN_W`=640, `SCREEN_H`=480
  - the mover state enum
- One sub-module, `frame_tick_gen`: the registered edge detector producing `frame_tick`.
- The bounds checker is instantiated alongside this block at the gym top level, not inside it.

## Test plan
1. **Reset and idle:** Reset, then idle ticks with no key → pos (224,340), `direction`=1, `moving`=0, `walk_frame`=0.
2. **One tile right:** hold D (0x07) for 1 tick, then release, `atBounds`=0 → `direction`=3 next cycle; after 16 further ticks x=240, y=340, back in IDLE; `walk_frame` sequence 0,1,2,3.
3. **Blocked step:** hold S with `atBounds` forced 1 in TURN → WALK aborts on the first tick, y unchanged at 340, `moving` drops.
4. **Mid-walk abort:** hold W; raise `atBounds` after 5 pixel steps → y=335, IDLE, counter 0.
5. **Freeze:** drop `move_en` for 10 ticks mid-walk → no position change. Raise it again → the walk completes the remaining pixels to a 16-pixel total.
6. **Screen edge and reset:** start at x=0 (via `START_X` override), hold A → no move, IDLE. Assert `Reset` mid-walk → start position restored in one cycle.
